// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding access to a word-wide DataMemory.
// Sub-word stores are performed as read-modify-write of the containing word.
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       write_data,
    output logic              write_enable,
    input  logic [31:0]       read_data
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [1:0]        state_q, state_d;
    logic              write_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [1:0]        lane_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] address_q;
    logic [31:0]       write_data_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;
    logic              req_err;

    function automatic logic access_error(input logic [1:0] size, input logic [1:0] lane);
        logic err;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = lane[0];
            SZ_WORD: err = |lane;
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] size,
                                                input logic sgn, input logic [1:0] lane);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] ext;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: ext = sgn ? 32'(b) : $signed({24'd0, b});
            SZ_HALF: ext = sgn ? 32'(h) : $signed({16'd0, h});
            default: ext = $signed(word);
        endcase
        return ext;
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] w;
        w = old;
        case (size)
            SZ_BYTE: w[{lane, 3'b000} +: 8]   = wdata[7:0];
            SZ_HALF: w[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: w = wdata;
        endcase
        return w;
    endfunction

    assign req_ready    = (state_q == IDLE);
    assign resp_valid   = (state_q == RESP);
    assign write_enable = (state_q == WRITE);
    assign address      = address_q;
    assign write_data   = write_data_q;
    assign resp_rdata   = resp_rdata_q;
    assign resp_err     = resp_err_q;
    assign req_err      = access_error(req_size, req_addr[1:0]);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)                              state_d = RESP;
                    else if (req_write && req_size == SZ_WORD) state_d = WRITE;
                    else                                      state_d = READ;
                end
            end
            READ:    state_d = write_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // Request fields are only meaningful while an access is in flight, so they need no reset.
    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            write_q  <= req_write;
            size_q   <= req_size;
            signed_q <= req_signed;
            lane_q   <= req_addr[1:0];
            wdata_q  <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            address_q    <= '0;
            write_data_q <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (req_err) begin
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            address_q <= {req_addr[ADDR_W-1:2], 2'b00};
                            if (req_write && req_size == SZ_WORD) write_data_q <= req_wdata;
                        end
                    end
                end
                READ: begin
                    if (write_q) begin
                        write_data_q <= merge_store(read_data, wdata_q, size_q, lane_q);
                    end else begin
                        resp_rdata_q <= extend_load(read_data, size_q, signed_q, lane_q);
                        resp_err_q   <= 1'b0;
                    end
                end
                WRITE: begin
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte-address width of core and memory ports.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1: core presents an access.
REQ-005 SHALL have port req_ready  output  1: unit accepts an access this cycle.
REQ-006 SHALL have port req_write  input  1: 1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 SHALL have port req_signed  input  1: sign-extend sub-word loads when 1.
REQ-009 SHALL have port req_addr  input  ADDR_W: byte address.
REQ-010 SHALL have port req_wdata  input  32: store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1: one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  32: load result, extended; 0 for stores.
REQ-013 SHALL have port resp_err  output  1: misaligned or illegal-size access, valid with resp_valid.
REQ-014 SHALL have port address  output  ADDR_W: word-aligned address to DataMemory.
REQ-015 SHALL have port write_data  output  32: word to DataMemory.
REQ-016 SHALL have port write_enable  output  1: DataMemory write strobe, one cycle per store.
REQ-017 SHALL have port read_data  input  32: word from DataMemory, sampled on the edge after address is driven.

Function
REQ-018 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-019 SHALL capture write, size, signed, addr, and wdata on the edge where req_valid && req_ready.
REQ-020 SHALL flag an error when size=11, when size=01 && addr[0]!=0, or when size=10 && addr[1:0]!=0; the transition is IDLE->RESP with no memory access.
REQ-021 SHALL sequence a word load as IDLE->READ->RESP, and a sub-word load the same way.
REQ-022 SHALL sequence a word store as IDLE->WRITE->RESP, with no read.
REQ-023 SHALL sequence a byte or halfword store as IDLE->READ->WRITE->RESP (read-modify-write): only the addressed lane(s) of the read word are replaced, and other lanes are written back unchanged.
REQ-024 SHALL use little-endian lanes: byte lane = addr[1:0]; halfword lane = addr[1] (bits 15:0 or 31:16).
REQ-025 SHALL drive address = {addr[ADDR_W-1:2], 2'b00} in READ and WRITE, and hold the last value otherwise.
REQ-026 SHALL assert write_enable only in WRITE, for exactly one cycle.
REQ-027 SHALL shift a loaded lane to bit 0 and zero-extend it, or sign-extend it when req_signed=1; a word load returns read_data unchanged.
REQ-028 SHALL give latencies from the accept edge to the resp_valid cycle of: load 2 cycles, word store 2, sub-word store 3, error 1.
REQ-029 SHALL assert resp_valid for exactly one cycle in RESP, then return to IDLE; there is no response backpressure.
REQ-030 SHALL allow a new request to be accepted in the cycle after RESP; back-to-back throughput is one access per 2-4 cycles.
REQ-031 SHALL ignore req_valid outside IDLE, with no queuing.
REQ-032 SHALL hold resp_rdata and resp_err stable until the next RESP.

Reset
REQ-033 SHALL, on rst_n=0 and asynchronously, force state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, write_enable=0, address=0, write_data=0.
REQ-034 SHALL abandon an access on reset mid-operation with no write issued after reset asserts; a RMW interrupted in READ SHALL leave memory unchanged.
REQ-035 SHALL accept the first request at the first rising edge with rst_n=1 and req_valid=1.

Verification
REQ-036 SHALL verify: word store 0x12345678 at 0x00, then word load at 0x00 -> write_enable pulses once with address 0x00; load resp_rdata=0x12345678 two cycles after accept.
REQ-037 SHALL verify: with mem[0x04]=0xAABBCCDD, store byte 0x5A at 0x06 -> write_data=0xAA5ACCDD to address 0x04; latency 3 cycles.
REQ-038 SHALL verify: with mem[0x04]=0xAABBCCDD, signed halfword load at 0x06 -> 0xFFFFAABB; unsigned byte load at 0x05 -> 0x000000CC.
REQ-039 SHALL verify: word load at 0x02 -> resp_err=1 one cycle after accept, with no READ state and no write_enable.
REQ-040 SHALL verify: rst_n pulled low during READ of a byte store -> outputs at reset values immediately, memory word unchanged, and a new request accepted after release.
REQ-041 SHALL verify: req_valid held high across a load -> req_ready=0 in READ/RESP; exactly one access is performed per accept.
